// File: rtl/ssp_pkg.sv
// Shared SSP widths and depths.
// The receive FIFO takes its parameter defaults from here.
package ssp_pkg;

    localparam int SSP_DATA_W   = 8;
    localparam int SSP_RX_DEPTH = 4;
    localparam int SSP_RX_PTR_W = $clog2(SSP_RX_DEPTH);
    localparam int SSP_RX_CNT_W = SSP_RX_PTR_W + 1;

endpackage : ssp_pkg

// File: rtl/ssp_rx_fifo.sv
// SSP receive FIFO: buffers bytes from the receive shifter until the APB host reads them.
// Define SSP_RX_OVERRUN_EN to build the sticky overrun flag on RXOVR.
module ssp_rx_fifo
    import ssp_pkg::*;
#(
    parameter int DATA_W = SSP_DATA_W,
    parameter int DEPTH  = SSP_RX_DEPTH
) (
    input  logic              PCLK,
    input  logic              CLEAR_B,
    input  logic              PSEL,
    input  logic              PWRITE,
    input  logic [DATA_W-1:0] RxData,
    input  logic              rxDone,
    output logic [DATA_W-1:0] PRDATA,
    output logic              validRx,
    output logic              SSPRXINTR,
    output logic              RXOVR
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic pop_req;
    logic pop_ok;
    logic push_ok;

    // Handshake: the receive side has no back-pressure; a push is taken when
    // there is room (or a pop frees a slot this cycle), otherwise dropped. A pop
    // is a host read that finds the FIFO non-empty; reads on empty are ignored.
    assign pop_req = PSEL & ~PWRITE;
    assign pop_ok  = pop_req && (count != '0);
    assign push_ok = rxDone && ((count != FULL_CNT) || pop_ok);

    assign validRx   = (count != '0);
    assign SSPRXINTR = (count == FULL_CNT);

    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            PRDATA <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= RxData;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            // When full with push and pop together, this reads the old byte
            // before the push overwrites the same slot.
            if (pop_ok) begin
                PRDATA <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef SSP_RX_OVERRUN_EN
    logic drop;
    logic ovr_q;

    assign drop = rxDone && !push_ok;

    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            ovr_q <= 1'b0;
        end else if (drop) begin
            ovr_q <= 1'b1;
        end
    end

    assign RXOVR = ovr_q;
`else
    assign RXOVR = 1'b0;
`endif

endmodule : ssp_rx_fifo

// File: tb/tb_ssp_rx_fifo.sv
// Directed bench for ssp_rx_fifo; expects RXOVR to follow SSP_RX_OVERRUN_EN.
module tb_ssp_rx_fifo;

    logic       PCLK;
    logic       CLEAR_B;
    logic       PSEL;
    logic       PWRITE;
    logic [7:0] RxData;
    logic       rxDone;
    logic [7:0] PRDATA;
    logic       validRx;
    logic       SSPRXINTR;
    logic       RXOVR;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q [$];
    logic [7:0] exp_b;
    logic       exp_ovr;

    ssp_rx_fifo dut (
        .PCLK      (PCLK),
        .CLEAR_B   (CLEAR_B),
        .PSEL      (PSEL),
        .PWRITE    (PWRITE),
        .RxData    (RxData),
        .rxDone    (rxDone),
        .PRDATA    (PRDATA),
        .validRx   (validRx),
        .SSPRXINTR (SSPRXINTR),
        .RXOVR     (RXOVR)
    );

    // clock / reset
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks: inputs change on the falling edge, outputs are sampled one
    // falling edge later, i.e. after the rising edge that consumed them
    task automatic tick(input logic push, input logic [7:0] d,
                        input logic rd, input logic wr);
        rxDone = push;
        RxData = d;
        PSEL   = rd;
        PWRITE = wr;
        @(negedge PCLK);
        rxDone = 1'b0;
        PSEL   = 1'b0;
        PWRITE = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        tick(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop();
        tick(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        CLEAR_B = 1'b0;
        @(negedge PCLK);
        CLEAR_B = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef SSP_RX_OVERRUN_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif
        CLEAR_B = 1'b0;
        PSEL    = 1'b0;
        PWRITE  = 1'b0;
        RxData  = 8'h00;
        rxDone  = 1'b0;
        @(negedge PCLK);
        do_reset();
        chk("rst_prdata", PRDATA, 8'h00);
        chk("rst_valid", validRx, 1'b0);
        chk("rst_full", SSPRXINTR, 1'b0);
        chk("rst_ovr", RXOVR, 1'b0);

        // three bytes in, three out, one cycle read latency
        push(8'hA1);
        chk("p1_valid", validRx, 1'b1);
        push(8'hB2);
        push(8'hC3);
        chk("p3_full", SSPRXINTR, 1'b0);
        pop();
        chk("r1_data", PRDATA, 8'hA1);
        pop();
        chk("r2_data", PRDATA, 8'hB2);
        chk("r2_valid", validRx, 1'b1);
        pop();
        chk("r3_data", PRDATA, 8'hC3);
        chk("r3_valid", validRx, 1'b0);

        // fill, overflow, drain
        push(8'h10);
        push(8'h11);
        push(8'h12);
        chk("f3_full", SSPRXINTR, 1'b0);
        push(8'h13);
        chk("f4_full", SSPRXINTR, 1'b1);
        chk("f4_ovr", RXOVR, 1'b0);
        push(8'h14);
        chk("ovf_full", SSPRXINTR, 1'b1);
        chk("ovf_ovr", RXOVR, exp_ovr);
        pop();
        chk("d1_data", PRDATA, 8'h10);
        chk("d1_full", SSPRXINTR, 1'b0);
        pop();
        chk("d2_data", PRDATA, 8'h11);
        pop();
        chk("d3_data", PRDATA, 8'h12);
        pop();
        chk("d4_data", PRDATA, 8'h13);
        chk("d4_valid", validRx, 1'b0);
        chk("d4_ovr_sticky", RXOVR, exp_ovr);

        // full plus simultaneous read and push
        do_reset();
        push(8'h20);
        push(8'h21);
        push(8'h22);
        push(8'h23);
        tick(1'b1, 8'h55, 1'b1, 1'b0);
        chk("fs_data", PRDATA, 8'h20);
        chk("fs_full", SSPRXINTR, 1'b1);
        chk("fs_ovr", RXOVR, 1'b0);
        pop();
        chk("fs_r1", PRDATA, 8'h21);
        pop();
        chk("fs_r2", PRDATA, 8'h22);
        pop();
        chk("fs_r3", PRDATA, 8'h23);
        pop();
        chk("fs_r4", PRDATA, 8'h55);
        chk("fs_valid", validRx, 1'b0);

        // empty plus simultaneous read and push: no bypass
        tick(1'b1, 8'h77, 1'b1, 1'b0);
        chk("es_hold", PRDATA, 8'h55);
        chk("es_valid", validRx, 1'b1);
        chk("es_full", SSPRXINTR, 1'b0);
        pop();
        chk("es_r1", PRDATA, 8'h77);
        chk("es_empty", validRx, 1'b0);

        // read on empty holds PRDATA
        pop();
        chk("empty_rd_hold", PRDATA, 8'h77);
        chk("empty_rd_valid", validRx, 1'b0);

        // host write is not a pop
        push(8'h88);
        tick(1'b0, 8'h00, 1'b1, 1'b1);
        chk("hw_hold", PRDATA, 8'h77);
        chk("hw_valid", validRx, 1'b1);
        pop();
        chk("hw_r1", PRDATA, 8'h88);
        chk("hw_empty", validRx, 1'b0);

        // two held, then sixteen push/pop pairs across several pointer wraps
        exp_q.delete();
        push(8'h40);
        exp_q.push_back(8'h40);
        push(8'h41);
        exp_q.push_back(8'h41);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            d = 8'(8'h50 + i * 7);
            tick(1'b1, d, 1'b1, 1'b0);
            exp_q.push_back(d);
            exp_b = exp_q.pop_front();
            chk("wrap_data", PRDATA, exp_b);
        end
        chk("wrap_valid", validRx, 1'b1);
        while (exp_q.size() > 0) begin
            pop();
            exp_b = exp_q.pop_front();
            chk("wrap_drain", PRDATA, exp_b);
        end
        chk("wrap_empty", validRx, 1'b0);

        // reset with two entries held and overrun raised
        push(8'h61);
        push(8'h62);
        push(8'h63);
        push(8'h64);
        push(8'h65);
        pop();
        pop();
        chk("pre_rst_data", PRDATA, 8'h62);
        chk("pre_rst_ovr", RXOVR, exp_ovr);
        chk("pre_rst_valid", validRx, 1'b1);
        do_reset();
        chk("clr_valid", validRx, 1'b0);
        chk("clr_prdata", PRDATA, 8'h00);
        chk("clr_ovr", RXOVR, 1'b0);
        chk("clr_full", SSPRXINTR, 1'b0);
        push(8'h99);
        pop();
        chk("post_clr_data", PRDATA, 8'h99);
        chk("post_clr_empty", validRx, 1'b0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ssp_rx_fifo

// File: doc/ssp_rx_fifo.md
Name: ssp_rx_fifo

Overview:
Receive-side FIFO of the SSP. Accepts parallel bytes from the SSP receive shift logic, one byte per `rxDone` strobe. Buffers them in a DEPTH-entry circular store. Returns them to the APB host on reads (PSEL=1, PWRITE=0). It is the counterpart of the transmit FIFO: it raises SSPRXINTR when full and flags overrun when a byte arrives with no room.

Parameters:
- DATA_W, 8, byte width of each entry and of PRDATA/RxData.
- DEPTH, 4, number of entries; must be a power of 2 and ≥2.

Ports:
- PCLK  input  1  clock; all logic on its rising edge.
- CLEAR_B  input  1  reset, synchronous, active-low.
- PSEL  input  1  APB chip select for the SSP FIFOs.
- PWRITE  input  1  1 = host write (ignored here), 0 = host read.
- RxData  input  DATA_W  byte assembled by the receive logic.
- rxDone  input  1  one-cycle strobe: RxData holds a complete received byte.
- PRDATA  output  DATA_W  registered byte returned to the host.
- validRx  output  1  FIFO non-empty.
- SSPRXINTR  output  1  FIFO full.
- RXOVR  output  1  sticky overrun flag.

Behaviour:
- State: mem[DEPTH], rd_ptr and wr_ptr, each log2(DEPTH) bits and wrapping modulo DEPTH, and count, log2(DEPTH)+1 bits.
- Reset, when CLEAR_B=0 at a PCLK edge: rd_ptr=0, wr_ptr=0, count=0, PRDATA=0, RXOVR=0, and all mem entries are set to 0. Reset overrides any simultaneous push or pop; a byte in flight is lost.
- Combinational outputs: validRx = (count != 0) and SSPRXINTR = (count == DEPTH).
- push_req = rxDone. pop_req = PSEL & ~PWRITE.
- Pop: if pop_req and count != 0:
  - PRDATA <= mem[rd_ptr] and rd_ptr <= rd_ptr+1.
  - Latency: the byte is visible on PRDATA in the cycle after the read request.
- Pop on empty: if pop_req and count == 0, PRDATA holds its previous value. Pointers and count do not change.
- Push: if push_req and the FIFO has room, mem[wr_ptr] <= RxData and wr_ptr <= wr_ptr+1. Room means count != DEPTH, or a pop succeeds in the same cycle.
- Push when full: if push_req, count == DEPTH and no pop occurs in the same cycle, the byte is dropped. Pointers and count are unchanged, and the overrun behaviour in Optional Feature applies.
- Simultaneous push and pop:
  - Both succeed when legal and count is unchanged.
  - When full, the pop frees the slot and the push is accepted; no overrun.
  - When empty, the push is accepted but the pop is the empty case. There is no bypass: the new byte is readable on the next read.
- count update: +1 for push only, -1 for pop only, unchanged for both or neither.
- Host writes (PSEL=1, PWRITE=1) have no effect on this block.
- Pointer wrap: after DEPTH pushes and pops, the pointers return to 0 with no disturbance to data order. Strict FIFO order is required.

Optional Feature:
Macro SSP_RX_OVERRUN_EN.
- Defined: RXOVR is set to 1 on any dropped push (see Push when full) and stays 1 until CLEAR_B=0. Reads do not clear it.
- Undefined: no flag register is built and RXOVR is tied to 0. Dropped pushes remain silent drops.

Decomposition:
- Package ssp_pkg holds:
  - SSP_DATA_W = 8 and SSP_RX_DEPTH = 4.
  - A pointer-width localparam, SSP_RX_PTR_W = $clog2(SSP_RX_DEPTH).
  - A count width, SSP_RX_PTR_W+1.
- Parameter defaults come from the package.
- No sub-module: storage, pointers and flags are small enough for a single module.

Test Plan:
- Reset, then three rxDone strobes with RxData 0xA1, 0xB2, 0xC3, then three reads → PRDATA shows 0xA1, 0xB2, 0xC3, each one cycle after its read. validRx drops after the third read.
- Four pushes 0x10..0x13 → SSPRXINTR=1 after the fourth. A fifth push of 0x14 is dropped; RXOVR=1 with SSP_RX_OVERRUN_EN defined, 0 without. Four reads return 0x10..0x13.
- FIFO full plus a read and rxDone (0x55) in the same cycle → no overrun, count stays 4, and the last read returns 0x55.
- FIFO empty plus a read and rxDone (0x77) in the same cycle → PRDATA holds its old value and validRx=1 next cycle. The next read returns 0x77.
- Sixteen interleaved push/pop pairs crossing the pointer wrap → output sequence equals input sequence. A read with PSEL=1, PWRITE=1 causes no pop.
- CLEAR_B=0 asserted with 2 entries held and RXOVR=1 → next cycle count=0, validRx=0, PRDATA=0x00, RXOVR=0.
